sd_spi_sniffer: RTL and testbench
=================================

Name: sd_spi_sniffer

Overview:
- Passive decoder for the SD-card SPI bus. Sits directly upstream of the SPI injector and produces its byte buffers and command/progress strobes.
- Samples MOSI and MISO on rising SCK (SPI mode 0) and keeps bytes aligned to CS_N.
- Tracks command frames, R1 responses, write-block data phases and busy periods.
- All outputs change only on rising CLK, so the injector can sample them cleanly on falling CLK.

Parameters:
- NCR_MAX, 8: maximum response-wait bytes after a CRC byte before the frame is abandoned.
- BLOCK_BYTES, 512: data bytes per write block, excluding the 2 CRC16 bytes.

Ports:
- CLK  in  1  SPI SCK; all state updates on rising edge.
- async_reset  in  1  asynchronous, active-high reset.
- CS_N  in  1  card chip select, active-low; high = bus deselected.
- MOSI  in  1  host-to-card data, taken after injector muxing.
- MISO  in  1  card-to-host data.
- MOSIBuffer  out  8  last complete MOSI byte.
- MISOBuffer  out  8  last complete MISO byte.
- BufferChanged  out  1  high for one CLK period after each byte completes.
- MOSICommand  out  6  command index of the current frame.
- MOSICommandReadFinished  out  1  command byte received.
- MOSIArgumentReadFinished  out  1  4 argument bytes received.
- MOSIArgument  out  32  argument, MSB first.
- MOSIReadSuccess  out  1  frame accepted.
- MOSIWaitingWriteToken  out  1  write command active, waiting for a host token.
- R1  out  8  last R1 response.
- dbg_state  out  4  FSM state.

Behaviour:
- Reset: all outputs 0 except MOSIBuffer = MISOBuffer = 8'hFF and R1 = 8'hFF. bitcnt = 0, state = IDLE.
- CS_N high at a rising edge:
  - bitcnt cleared and state forced to IDLE.
  - All flags cleared.
  - Buffers and MOSICommand held.
- Shifting and byte timing:
  - Shift registers take MSB first.
  - Byte completes at the 8th rising edge after bitcnt = 0.
  - On that edge, both buffers load and BufferChanged = 1. It clears on the next edge (1-cycle pulse).
  - bitcnt is 3-bit and wraps.
- FSM (advances only on byte-complete edges):
  - IDLE:
    - Clears all flags.
    - A MOSI byte[7:6] = 2'b01 sets MOSICommand = byte[5:0] and MOSICommandReadFinished = 1, then goes to ARG.
    - Otherwise stays in IDLE.
  - ARG:
    - Collects 4 bytes into MOSIArgument.
    - After the 4th byte: MOSIArgumentReadFinished = 1, go to CRC.
  - CRC:
    - Byte accepted → MOSIReadSuccess = 1, go to RESP.
    - Byte rejected → go to IDLE with flags cleared.
    - Acceptance rule is given under Optional Feature.
  - RESP:
    - Counts MISO bytes.
    - First MISO byte with bit7 = 0: R1 = byte.
      - If MOSICommand ∈ {24, 25} and R1 == 0: go to WTOKEN.
      - Else: stay in IDLE-wait. MOSIReadSuccess stays high until CS_N high or the next command start byte.
    - Count exceeds NCR_MAX: go to IDLE and clear MOSIReadSuccess.
  - WTOKEN:
    - MOSIWaitingWriteToken = 1.
    - MOSI 8'hFE (CMD24) or 8'hFC (CMD25): go to DATA.
    - MOSI 8'hFD with CMD25: go to BUSY_END.
    - Other bytes (8'hFF): ignored.
    - On leaving the state, MOSIWaitingWriteToken = 0.
  - DATA:
    - Counts BLOCK_BYTES + 2 bytes with a 10-bit counter, then goes to DRESP.
  - DRESP:
    - Consumes the first MISO byte with bit4 = 0 and bit0 = 1 as the data response.
    - Then goes to BUSY.
  - BUSY:
    - Waits for a MISO byte != 8'h00.
    - CMD25: return to WTOKEN.
    - CMD24: go to IDLE with MOSIReadSuccess = 0.
  - BUSY_END:
    - Waits for a MISO byte != 8'h00 after the stop token.
    - Then goes to IDLE with MOSIReadSuccess = 0.
- Simultaneous events:
  - CS_N high has priority over byte completion.
  - In any state except DATA, a command start byte while MOSIReadSuccess = 1 restarts decoding at ARG.
- Latency: flags assert on the same edge that completes the byte.

Optional Feature:
- Macro: SNIFF_CRC7_CHECK_EN.
- Defined:
  - CRC7 (poly x^7+x^3+1, init 0) is computed over the command byte and argument bytes.
  - CRC byte accepted iff byte[7:1] == CRC7 and byte[0] == 1.
- Undefined: accepted iff byte[0] == 1 (end bit only); the CRC logic is not synthesised.

Test Plan:
- Reset, then CS_N low, MOSI 40 00 00 00 00 95 (CMD0), MISO 01 on the 2nd response byte → MOSICommand = 0, MOSIArgument = 0, MOSIReadSuccess = 1, R1 = 8'h01.
- CMD24 frame with arg 0x00001000, R1 = 00, token FE, 514 data bytes, MISO E5 then 00 00 FF → MOSIWaitingWriteToken high then low; MOSIReadSuccess falls after the FF byte; dbg_state returns to IDLE.
- CMD25, two FC blocks, then FD and busy 00 → MOSIWaitingWriteToken re-asserts after each busy; MOSIReadSuccess falls after busy ends.
- With SNIFF_CRC7_CHECK_EN, CMD0 sent with CRC byte 8'h94 → MOSIReadSuccess stays 0, state IDLE.
- CS_N driven high mid-ARG → all flags 0 on the next edge; a new frame decodes correctly.
- 9 MISO FF bytes after CRC (NCR_MAX = 8) → MOSIReadSuccess clears, state IDLE.

Source files
------------

// File: rtl/sd_spi_sniffer_if.sv
// ============================================================================
// Module  : sd_spi_sniffer_if
// Brief   : SD-card SPI bus signals (chip select, MOSI, MISO) as seen by the sniffer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface sd_spi_sniffer_if;
    logic CS_N;
    logic MOSI;
    logic MISO;

    modport master (output CS_N, MOSI, MISO);
    modport slave  (input  CS_N, MOSI, MISO);
endinterface

`default_nettype wire

// File: rtl/sd_spi_sniffer.sv
// ============================================================================
// Module  : sd_spi_sniffer
// Brief   : Passive SD SPI decoder: byte buffers, command/argument/R1 capture and
//           write-block tracking. Optional macro SNIFF_CRC7_CHECK_EN adds CRC7 check.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sd_spi_sniffer #(
    parameter int NCR_MAX     = 8,
    parameter int BLOCK_BYTES = 512
) (
    input  logic               CLK,
    input  logic               async_reset,
    sd_spi_sniffer_if.slave    bus,
    output logic [7:0]         MOSIBuffer,
    output logic [7:0]         MISOBuffer,
    output logic               BufferChanged,
    output logic [5:0]         MOSICommand,
    output logic               MOSICommandReadFinished,
    output logic               MOSIArgumentReadFinished,
    output logic [31:0]        MOSIArgument,
    output logic               MOSIReadSuccess,
    output logic               MOSIWaitingWriteToken,
    output logic [7:0]         R1,
    output logic [3:0]         dbg_state
);

    localparam int NCR_W = $clog2(NCR_MAX + 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ARG      = 4'd1,
        ST_CRC      = 4'd2,
        ST_RESP     = 4'd3,
        ST_WTOKEN   = 4'd4,
        ST_DATA     = 4'd5,
        ST_DRESP    = 4'd6,
        ST_BUSY     = 4'd7,
        ST_BUSY_END = 4'd8
    } state_t;

    state_t             state;
    logic [2:0]         bitcnt;
    logic [6:0]         mosi_sr;
    logic [6:0]         miso_sr;
    logic [1:0]         arg_cnt;
    logic [NCR_W-1:0]   ncr_cnt;
    logic [9:0]         data_cnt;

    logic               byte_done;
    logic [7:0]         mosi_byte;
    logic [7:0]         miso_byte;
    logic               cmd_start;
    logic               is_wr_cmd;
    logic               crc_ok;

    assign byte_done = (bitcnt == 3'd7);
    assign mosi_byte = {mosi_sr, bus.MOSI};
    assign miso_byte = {miso_sr, bus.MISO};
    assign is_wr_cmd = (MOSICommand == 6'd24) || (MOSICommand == 6'd25);
    assign dbg_state = state;

    // A start byte re-syncs decoding from IDLE, or mid-transaction once a frame was
    // accepted; never inside a data block where payload bytes may look like commands.
    assign cmd_start = (mosi_byte[7:6] == 2'b01) &&
                       ((state == ST_IDLE) || (MOSIReadSuccess && (state != ST_DATA)));

`ifdef SNIFF_CRC7_CHECK_EN
    logic [6:0] crc7;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    always_ff @(posedge CLK or posedge async_reset) begin
        if (async_reset) begin
            crc7 <= 7'd0;
        end else if (!bus.CS_N && byte_done) begin
            if (cmd_start) begin
                crc7 <= crc7_step(7'd0, mosi_byte);
            end else if (state == ST_ARG) begin
                crc7 <= crc7_step(crc7, mosi_byte);
            end
        end
    end

    assign crc_ok = (mosi_byte[7:1] == crc7) && mosi_byte[0];
`else
    assign crc_ok = mosi_byte[0];
`endif

    always_ff @(posedge CLK or posedge async_reset) begin
        if (async_reset) begin
            state                    <= ST_IDLE;
            bitcnt                   <= 3'd0;
            mosi_sr                  <= 7'd0;
            miso_sr                  <= 7'd0;
            arg_cnt                  <= 2'd0;
            ncr_cnt                  <= '0;
            data_cnt                 <= 10'd0;
            MOSIBuffer               <= 8'hFF;
            MISOBuffer               <= 8'hFF;
            BufferChanged            <= 1'b0;
            MOSICommand              <= 6'd0;
            MOSICommandReadFinished  <= 1'b0;
            MOSIArgumentReadFinished <= 1'b0;
            MOSIArgument             <= 32'd0;
            MOSIReadSuccess          <= 1'b0;
            MOSIWaitingWriteToken    <= 1'b0;
            R1                       <= 8'hFF;
        end else if (bus.CS_N) begin
            bitcnt                   <= 3'd0;
            state                    <= ST_IDLE;
            BufferChanged            <= 1'b0;
            MOSICommandReadFinished  <= 1'b0;
            MOSIArgumentReadFinished <= 1'b0;
            MOSIReadSuccess          <= 1'b0;
            MOSIWaitingWriteToken    <= 1'b0;
        end else begin
            bitcnt        <= bitcnt + 3'd1;
            mosi_sr       <= mosi_byte[6:0];
            miso_sr       <= miso_byte[6:0];
            BufferChanged <= byte_done;
            if (byte_done) begin
                MOSIBuffer <= mosi_byte;
                MISOBuffer <= miso_byte;
                if (cmd_start) begin
                    MOSICommand              <= mosi_byte[5:0];
                    MOSICommandReadFinished  <= 1'b1;
                    MOSIArgumentReadFinished <= 1'b0;
                    MOSIReadSuccess          <= 1'b0;
                    MOSIWaitingWriteToken    <= 1'b0;
                    arg_cnt                  <= 2'd0;
                    state                    <= ST_ARG;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            MOSICommandReadFinished  <= 1'b0;
                            MOSIArgumentReadFinished <= 1'b0;
                            MOSIWaitingWriteToken    <= 1'b0;
                        end
                        ST_ARG: begin
                            MOSIArgument <= {MOSIArgument[23:0], mosi_byte};
                            arg_cnt      <= arg_cnt + 2'd1;
                            if (arg_cnt == 2'd3) begin
                                MOSIArgumentReadFinished <= 1'b1;
                                state                    <= ST_CRC;
                            end
                        end
                        ST_CRC: begin
                            if (crc_ok) begin
                                MOSIReadSuccess <= 1'b1;
                                ncr_cnt         <= '0;
                                state           <= ST_RESP;
                            end else begin
                                MOSICommandReadFinished  <= 1'b0;
                                MOSIArgumentReadFinished <= 1'b0;
                                state                    <= ST_IDLE;
                            end
                        end
                        ST_RESP: begin
                            if (!miso_byte[7]) begin
                                R1 <= miso_byte;
                                if (is_wr_cmd && (miso_byte == 8'h00)) begin
                                    MOSIWaitingWriteToken <= 1'b1;
                                    state                 <= ST_WTOKEN;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end else if (ncr_cnt == NCR_W'(NCR_MAX)) begin
                                MOSIReadSuccess <= 1'b0;
                                state           <= ST_IDLE;
                            end else begin
                                ncr_cnt <= ncr_cnt + 1'b1;
                            end
                        end
                        ST_WTOKEN: begin
                            if (((mosi_byte == 8'hFE) && (MOSICommand == 6'd24)) ||
                                ((mosi_byte == 8'hFC) && (MOSICommand == 6'd25))) begin
                                MOSIWaitingWriteToken <= 1'b0;
                                data_cnt              <= 10'd0;
                                state                 <= ST_DATA;
                            end else if ((mosi_byte == 8'hFD) && (MOSICommand == 6'd25)) begin
                                MOSIWaitingWriteToken <= 1'b0;
                                state                 <= ST_BUSY_END;
                            end
                        end
                        ST_DATA: begin
                            // Payload plus the two CRC16 bytes.
                            if (data_cnt == 10'(BLOCK_BYTES + 1)) begin
                                state <= ST_DRESP;
                            end else begin
                                data_cnt <= data_cnt + 10'd1;
                            end
                        end
                        ST_DRESP: begin
                            if (!miso_byte[4] && miso_byte[0]) begin
                                state <= ST_BUSY;
                            end
                        end
                        ST_BUSY: begin
                            if (miso_byte != 8'h00) begin
                                if (MOSICommand == 6'd25) begin
                                    MOSIWaitingWriteToken <= 1'b1;
                                    state                 <= ST_WTOKEN;
                                end else begin
                                    MOSIReadSuccess <= 1'b0;
                                    state           <= ST_IDLE;
                                end
                            end
                        end
                        ST_BUSY_END: begin
                            if (miso_byte != 8'h00) begin
                                MOSIReadSuccess <= 1'b0;
                                state           <= ST_IDLE;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sd_spi_sniffer.sv
// ============================================================================
// Module  : tb_sd_spi_sniffer
// Brief   : Directed self-checking bench for sd_spi_sniffer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sd_spi_sniffer;

    localparam logic [3:0] S_IDLE = 4'd0, S_ARG = 4'd1, S_CRC = 4'd2, S_RESP = 4'd3,
                           S_WTOK = 4'd4, S_DATA = 4'd5, S_DRESP = 4'd6, S_BUSY = 4'd7,
                           S_BEND = 4'd8;

    logic        CLK = 1'b0;
    logic        async_reset;
    logic [7:0]  MOSIBuffer, MISOBuffer, R1;
    logic        BufferChanged, MOSICommandReadFinished, MOSIArgumentReadFinished;
    logic        MOSIReadSuccess, MOSIWaitingWriteToken;
    logic [5:0]  MOSICommand;
    logic [31:0] MOSIArgument;
    logic [3:0]  dbg_state;

    int   n_cmp = 0;
    int   n_err = 0;
    logic bc_mid;

    sd_spi_sniffer_if bus ();

    sd_spi_sniffer #(.NCR_MAX(8), .BLOCK_BYTES(512)) dut (
        .CLK                      (CLK),
        .async_reset              (async_reset),
        .bus                      (bus),
        .MOSIBuffer               (MOSIBuffer),
        .MISOBuffer               (MISOBuffer),
        .BufferChanged            (BufferChanged),
        .MOSICommand              (MOSICommand),
        .MOSICommandReadFinished  (MOSICommandReadFinished),
        .MOSIArgumentReadFinished (MOSIArgumentReadFinished),
        .MOSIArgument             (MOSIArgument),
        .MOSIReadSuccess          (MOSIReadSuccess),
        .MOSIWaitingWriteToken    (MOSIWaitingWriteToken),
        .R1                       (R1),
        .dbg_state                (dbg_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7_model(input logic [39:0] bits);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ bits[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // Drive bits on falling CLK; return just after the byte-completing rising edge.
    task automatic send_byte(input logic [7:0] m, input logic [7:0] s);
        for (int i = 7; i >= 0; i--) begin
            @(negedge CLK);
            bus.CS_N = 1'b0;
            bus.MOSI = m[i];
            bus.MISO = s[i];
            @(posedge CLK);
            #1;
            if (i == 7) bc_mid = BufferChanged;
        end
    endtask

    task automatic cs_deselect();
        @(negedge CLK);
        bus.CS_N = 1'b1;
        bus.MOSI = 1'b1;
        bus.MISO = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic [5:0] cmd, input logic [31:0] arg);
        logic [39:0] f;
        f = {2'b01, cmd, arg};
        send_byte(f[39:32], 8'hFF);
        send_byte(f[31:24], 8'hFF);
        send_byte(f[23:16], 8'hFF);
        send_byte(f[15:8],  8'hFF);
        send_byte(f[7:0],   8'hFF);
        send_byte({crc7_model(f), 1'b1}, 8'hFF);
    endtask

    task automatic send_block(input logic [7:0] token, input string tag);
        send_byte(token, 8'hFF);
        check({tag, " token->DATA"}, dbg_state, S_DATA);
        check({tag, " wait low"}, MOSIWaitingWriteToken, 1'b0);
        for (int i = 0; i < 513; i++) send_byte(8'(i), 8'hFF);
        check({tag, " 513 bytes still DATA"}, dbg_state, S_DATA);
        send_byte(8'hA5, 8'hFF);
        check({tag, " 514 bytes->DRESP"}, dbg_state, S_DRESP);
        send_byte(8'hFF, 8'hE5);
        check({tag, " dresp->BUSY"}, dbg_state, S_BUSY);
        send_byte(8'hFF, 8'h00);
        check({tag, " busy holds"}, dbg_state, S_BUSY);
    endtask

    initial begin
        async_reset = 1'b1;
        bus.CS_N = 1'b1;
        bus.MOSI = 1'b1;
        bus.MISO = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst MOSIBuffer", MOSIBuffer, 8'hFF);
        check("rst MISOBuffer", MISOBuffer, 8'hFF);
        check("rst R1", R1, 8'hFF);
        check("rst BufferChanged", BufferChanged, 1'b0);
        check("rst ReadSuccess", MOSIReadSuccess, 1'b0);
        check("rst Argument", MOSIArgument, 32'd0);
        check("rst state", dbg_state, S_IDLE);
        @(negedge CLK);
        async_reset = 1'b0;

        // CMD0 with its well-known CRC byte 0x95
        send_byte(8'h40, 8'hFF);
        check("cmd0 cmd fin", MOSICommandReadFinished, 1'b1);
        check("cmd0 index", MOSICommand, 6'd0);
        check("cmd0 BufferChanged", BufferChanged, 1'b1);
        check("cmd0 MOSIBuffer", MOSIBuffer, 8'h40);
        check("cmd0 state ARG", dbg_state, S_ARG);
        repeat (3) send_byte(8'h00, 8'hFF);
        check("bc pulse clears", bc_mid, 1'b0);
        check("arg fin low at 3", MOSIArgumentReadFinished, 1'b0);
        send_byte(8'h00, 8'hFF);
        check("arg fin", MOSIArgumentReadFinished, 1'b1);
        check("state CRC", dbg_state, S_CRC);
        send_byte(8'h95, 8'hFF);
        check("cmd0 success", MOSIReadSuccess, 1'b1);
        check("state RESP", dbg_state, S_RESP);
        send_byte(8'hFF, 8'hFF);
        check("ncr1 R1 held", R1, 8'hFF);
        send_byte(8'hFF, 8'h01);
        check("cmd0 R1", R1, 8'h01);
        check("cmd0 MISOBuffer", MISOBuffer, 8'h01);
        check("cmd0 arg", MOSIArgument, 32'd0);
        check("cmd0 idle", dbg_state, S_IDLE);
        check("cmd0 success held", MOSIReadSuccess, 1'b1);
        send_byte(8'hFF, 8'hFF);
        check("idle success held", MOSIReadSuccess, 1'b1);
        check("idle cmd fin clr", MOSICommandReadFinished, 1'b0);
        send_byte(8'h48, 8'hFF);
        check("restart ARG", dbg_state, S_ARG);
        check("restart success clr", MOSIReadSuccess, 1'b0);
        check("restart index", MOSICommand, 6'd8);
        cs_deselect();
        check("cs cmd fin", MOSICommandReadFinished, 1'b0);
        check("cs state", dbg_state, S_IDLE);
        check("cs cmd held", MOSICommand, 6'd8);
        check("cs buf held", MOSIBuffer, 8'h48);

        // CMD24 single-block write
        send_cmd(6'd24, 32'h0000_1000);
        check("cmd24 index", MOSICommand, 6'd24);
        check("cmd24 arg", MOSIArgument, 32'h0000_1000);
        check("cmd24 success", MOSIReadSuccess, 1'b1);
        send_byte(8'hFF, 8'h00);
        check("cmd24 R1", R1, 8'h00);
        check("cmd24 WTOK", dbg_state, S_WTOK);
        check("cmd24 wait high", MOSIWaitingWriteToken, 1'b1);
        send_byte(8'hFF, 8'hFF);
        check("cmd24 FF ignored", dbg_state, S_WTOK);
        send_block(8'hFE, "cmd24");
        check("cmd24 last data", MOSIBuffer, 8'hFF);
        send_byte(8'hFF, 8'h00);
        check("cmd24 busy success", MOSIReadSuccess, 1'b1);
        send_byte(8'hFF, 8'hFF);
        check("cmd24 done idle", dbg_state, S_IDLE);
        check("cmd24 success clr", MOSIReadSuccess, 1'b0);
        cs_deselect();

        // CMD25 multi-block write, two blocks then stop token
        send_cmd(6'd25, 32'h0000_0200);
        send_byte(8'hFF, 8'h00);
        check("cmd25 WTOK", dbg_state, S_WTOK);
        for (int b = 0; b < 2; b++) begin
            send_block(8'hFC, "cmd25");
            send_byte(8'hFF, 8'hFF);
            check("cmd25 back to WTOK", dbg_state, S_WTOK);
            check("cmd25 wait reasserts", MOSIWaitingWriteToken, 1'b1);
        end
        send_byte(8'hFD, 8'hFF);
        check("cmd25 stop BEND", dbg_state, S_BEND);
        check("cmd25 stop wait low", MOSIWaitingWriteToken, 1'b0);
        send_byte(8'hFF, 8'h00);
        check("cmd25 busy success", MOSIReadSuccess, 1'b1);
        send_byte(8'hFF, 8'hFF);
        check("cmd25 end idle", dbg_state, S_IDLE);
        check("cmd25 success clr", MOSIReadSuccess, 1'b0);
        cs_deselect();

        // Bad CRC bytes
        send_byte(8'h40, 8'hFF);
        repeat (4) send_byte(8'h00, 8'hFF);
        send_byte(8'h94, 8'hFF);
        check("crc94 success", MOSIReadSuccess, 1'b0);
        check("crc94 idle", dbg_state, S_IDLE);
        check("crc94 cmd fin clr", MOSICommandReadFinished, 1'b0);
        send_byte(8'h40, 8'hFF);
        repeat (4) send_byte(8'h00, 8'hFF);
        send_byte(8'h97, 8'hFF);
`ifdef SNIFF_CRC7_CHECK_EN
        check("crc97 success", MOSIReadSuccess, 1'b0);
        check("crc97 state", dbg_state, S_IDLE);
`else
        check("crc97 success", MOSIReadSuccess, 1'b1);
        check("crc97 state", dbg_state, S_RESP);
`endif
        cs_deselect();

        // CS_N high mid-argument, with a partial byte in flight
        send_byte(8'h51, 8'hFF);
        send_byte(8'h00, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus.CS_N = 1'b0;
            bus.MOSI = 1'b1;
            @(posedge CLK);
        end
        cs_deselect();
        check("midarg cmd fin", MOSICommandReadFinished, 1'b0);
        check("midarg arg fin", MOSIArgumentReadFinished, 1'b0);
        check("midarg BufferChanged", BufferChanged, 1'b0);
        check("midarg state", dbg_state, S_IDLE);
        check("midarg cmd held", MOSICommand, 6'd17);
        send_cmd(6'd8, 32'h0000_01AA);
        check("cmd8 index", MOSICommand, 6'd8);
        check("cmd8 arg", MOSIArgument, 32'h0000_01AA);
        check("cmd8 success", MOSIReadSuccess, 1'b1);
        send_byte(8'hFF, 8'h01);
        check("cmd8 R1", R1, 8'h01);
        cs_deselect();

        // Response timeout
        send_cmd(6'd0, 32'd0);
        repeat (8) send_byte(8'hFF, 8'hFF);
        check("ncr8 still RESP", dbg_state, S_RESP);
        check("ncr8 success", MOSIReadSuccess, 1'b1);
        send_byte(8'hFF, 8'hFF);
        check("ncr9 idle", dbg_state, S_IDLE);
        check("ncr9 success clr", MOSIReadSuccess, 1'b0);
        check("ncr9 R1 held", R1, 8'h01);
        cs_deselect();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
